uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte FIFO between the UART receiver's data_ready/data outputs and the UART transmitter's en/data_in/rdy inputs. It absorbs back-to-back received bytes while the transmitter is busy and issues exactly one single-cycle transmit strobe per stored byte. It replaces the direct rx-to-tx wire in the loopback top, so bytes are no longer lost when input arrives faster than the line drains. It reports fill level and a sticky overflow flag for LEDs or debug.

Parameters:
WIDTH, 8, data width in bits.
DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (16).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  synchronous, active-low reset.
wr_en  input  1  single-cycle write strobe (receiver data_ready).
wr_data  input  WIDTH  byte to store, valid while wr_en=1.
tx_rdy  input  1  transmitter idle/ready.
tx_en  output  1  single-cycle transmit start strobe (registered).
tx_data  output  WIDTH  byte for the transmitter; held stable from tx_en until the next launch.
count  output  DEPTH_LOG2+1  number of stored entries, 0..DEPTH.
empty  output  1  count==0.
full  output  1  count==DEPTH.
overflow  output  1  sticky: a write was dropped.
clr_overflow  input  1  clears overflow.

Behaviour:
- Reset (rst_n=0 at a clock edge): rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overflow=0, tx_en=0, tx_data=0, state=IDLE. Memory contents are don't-care. Reset overrides every other input, including a launch in progress. After reset, tx_en never re-fires for a byte that was pending before reset.
- Storage: DEPTH x WIDTH array with pointers of DEPTH_LOG2 bits that wrap modulo DEPTH naturally. count is a separate register.
- Write: if wr_en=1 and full=0, then mem[wr_ptr]<=wr_data and wr_ptr++.
- Dropped write: if wr_en=1 and full=1, the write is dropped, pointers are unchanged, and overflow<=1. The full check uses the current count even if a pop occurs in the same cycle.
- Overflow clear: clr_overflow=1 clears overflow. If a dropped write and clr_overflow occur in the same cycle, set wins.
- Pop: happens only on a launch. Every launch pops exactly one entry.
- Count update: write only gives count+1; pop only gives count-1; write and pop in the same cycle leave count unchanged. count never exceeds DEPTH and never goes below 0.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if empty=0 and tx_rdy=1, launch: tx_data<=mem[rd_ptr], tx_en<=1 for exactly one cycle, rd_ptr++, go to WAIT_BUSY. Otherwise tx_en<=0.
  - WAIT_BUSY: tx_en<=0; wait for tx_rdy=0, then go to WAIT_DONE. The transmitter drops rdy within 2 cycles of en; this state prevents a double launch while tx_rdy is still high.
  - WAIT_DONE: wait for tx_rdy=1, then go to IDLE. The next launch can happen one cycle later at the earliest.
- Latency: wr_en into an empty FIFO while IDLE and tx_rdy=1 is accepted at edge N. empty=0 is visible in cycle N+1. tx_en=1 with tx_data=byte is visible in cycle N+2.
- Same-cycle write and launch: the launch uses the pre-write state, so a write into an empty FIFO cannot launch in the same cycle.
- tx_data is don't-care-free: it holds the last launched byte indefinitely.
- Ordering: bytes leave strictly in write order.

Test Plan:
1. Reset then single byte: wr_en pulse with 0xA5, tx_rdy=1 (model transmitter drops rdy 1 cycle after en and raises it 10 cycles later) -> tx_en high for exactly one cycle, 2 cycles after the write, with tx_data=0xA5. count goes 0->1->0 and empty returns to 1.
2. Burst: 5 writes 0x01..0x05 on consecutive cycles while the transmitter is busy -> count=5. Then exactly 5 tx_en pulses carrying 0x01..0x05 in order, each after tx_rdy returns high. No extra pulse follows.
3. Fill and overflow: tx_rdy=0, write 17 bytes 0x10..0x20 -> full=1 at count=16 and overflow=1. Byte 0x20 is dropped. After draining, the output is 0x10..0x1F.
4. Wrap-around: 40 bytes written at one per 3 cycles with a fast transmitter -> all 40 are delivered in order and count never exceeds 2.
5. Simultaneous events: with full=1, in one cycle assert wr_en and a launch from IDLE -> write dropped, overflow=1, count=15. In the same cycle as a dropped write, clr_overflow=1 -> overflow stays 1. clr_overflow alone -> overflow=0.
6. Reset mid-operation: rst_n=0 during WAIT_DONE with 3 entries queued -> next cycle count=0, empty=1, tx_en=0, state=IDLE. No tx_en after tx_rdy rises.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO sitting between the UART receiver and the UART transmitter in
//   the loopback top. Received bytes are queued while the transmitter is
//   busy. Each stored byte produces exactly one single-cycle transmit strobe.
//
// Ports:
//   clk           system clock; all logic runs on the rising edge
//   rst_n         synchronous, active-low reset
//   wr_en         single-cycle write strobe (receiver data_ready)
//   wr_data       byte to store, valid while wr_en=1
//   tx_rdy        transmitter idle/ready
//   tx_en         single-cycle transmit start strobe (registered)
//   tx_data       byte for the transmitter; holds the last launched byte
//   count         number of stored entries, 0..DEPTH
//   empty         count == 0
//   full          count == DEPTH
//   overflow      sticky flag: a write was dropped because the FIFO was full
//   clr_overflow  clears overflow (a simultaneous dropped write wins)
module uart_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  tx_rdy,
  output logic                  tx_en,
  output logic [WIDTH-1:0]      tx_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  overflow_reg;
  logic                  tx_en_reg;
  logic [WIDTH-1:0]      tx_data_reg;
  state_t                state_reg;
  state_t                state_next;

  logic                  wr_accept;
  logic                  launch;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_FULL);
  // The full test uses the current count, so a pop in the same cycle does
  // not make room for this cycle's write.
  assign wr_accept = wr_en && !full;

  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign tx_en     = tx_en_reg;
  assign tx_data   = tx_data_reg;

  // Launch sequencing. WAIT_BUSY guards against a second launch while the
  // transmitter has not yet dropped rdy in response to the strobe.
  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!empty && tx_rdy) begin
          launch     = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!tx_rdy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Storage array: write port only, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Control, pointers, count and the registered read into tx_data.
  // When launch is active the FIFO is non-empty, and an accepted write
  // implies it is not full, so wr_ptr never aliases rd_ptr here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      tx_en_reg    <= 1'b0;
      tx_data_reg  <= '0;
      state_reg    <= IDLE;
    end else begin
      state_reg <= state_next;
      tx_en_reg <= launch;

      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end

      if (launch) begin
        tx_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
      end

      if (wr_accept && !launch) begin
        count_reg <= count_reg + CNT_ONE;
      end else if (!wr_accept && launch) begin
        count_reg <= count_reg - CNT_ONE;
      end

      // A dropped write in the same cycle as a clear keeps the flag set.
      if (wr_en && full) begin
        overflow_reg <= 1'b1;
      end else if (clr_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. A small transmitter model drives tx_rdy
//   (automatic: drops rdy after each strobe and raises it busy_len cycles
//   later; manual: rdy follows tx_manual). A monitor logs every launched byte.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_rdy = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       clr_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  bit tx_auto   = 1'b1;
  bit tx_manual = 1'b0;
  int busy_len  = 10;
  int busy_cnt  = 0;

  logic [7:0] got[$];
  int   pulses     = 0;
  int   doubles    = 0;
  logic prev_tx_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .tx_rdy       (tx_rdy),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Transmitter model, updated on the falling edge.
  always @(negedge clk) begin
    if (!tx_auto) begin
      tx_rdy   = tx_manual;
      busy_cnt = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_rdy = 1'b1;
    end else if (tx_en) begin
      tx_rdy   = 1'b0;
      busy_cnt = busy_len;
    end else begin
      tx_rdy = 1'b1;
    end
  end

  // Launch monitor: one line per transmitted byte.
  always @(negedge clk) begin
    if (tx_en) begin
      got.push_back(tx_data);
      pulses++;
      if (prev_tx_en) doubles++;
      $display("tx byte 0x%02h (launch %0d)", tx_data, pulses);
    end
    prev_tx_en = tx_en;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int n = 0;
    while (!(empty && tx_rdy && !tx_en && busy_cnt == 0) && n < budget) begin
      tick();
      n++;
    end
    tick();
    check({tag, "_drained"}, 32'(n < budget), 32'd1);
  endtask

  task automatic clear_log();
    got.delete();
    pulses = 0;
  endtask

  initial begin
    int max_cnt;

    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    clr_overflow = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_en",    32'(tx_en),    32'd0);
    check("rst_tx_data",  32'(tx_data),  32'h00);
    rst_n = 1'b1;
    tick();

    // 1: single byte, two-cycle latency to the strobe
    clear_log();
    write_byte(8'hA5);
    check("t1_count_n1", 32'(count), 32'd1);
    check("t1_empty_n1", 32'(empty), 32'd0);
    check("t1_tx_en_n1", 32'(tx_en), 32'd0);
    tick();
    check("t1_tx_en_n2",   32'(tx_en),   32'd1);
    check("t1_tx_data_n2", 32'(tx_data), 32'hA5);
    check("t1_count_n2",   32'(count),   32'd0);
    check("t1_empty_n2",   32'(empty),   32'd1);
    tick();
    check("t1_tx_en_n3",   32'(tx_en),   32'd0);
    check("t1_tx_data_n3", 32'(tx_data), 32'hA5);
    wait_drained("t1", 200);
    check("t1_pulses", 32'(pulses), 32'd1);

    // 2: burst of five while the transmitter is busy
    clear_log();
    tx_auto   = 1'b0;
    tx_manual = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    check("t2_count", 32'(count), 32'd5);
    tx_auto = 1'b1;
    wait_drained("t2", 500);
    repeat (20) tick();
    check("t2_pulses", 32'(pulses), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) check($sformatf("t2_byte%0d", i), 32'(got[i]), 32'(i + 1));

    // 3: fill to DEPTH, seventeenth write dropped
    clear_log();
    tx_auto   = 1'b0;
    tx_manual = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) write_byte(8'h10 + 8'(i));
    check("t3_count16",    32'(count),    32'd16);
    check("t3_full16",     32'(full),     32'd1);
    check("t3_overflow16", 32'(overflow), 32'd0);
    write_byte(8'h20);
    check("t3_count17",    32'(count),    32'd16);
    check("t3_overflow17", 32'(overflow), 32'd1);
    tx_auto = 1'b1;
    wait_drained("t3", 2000);
    check("t3_pulses", 32'(pulses), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < got.size()) check($sformatf("t3_byte%0d", i), 32'(got[i]), 32'h10 + 32'(i));
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3_overflow_clr", 32'(overflow), 32'd0);

    // 4: wrap-around with a fast transmitter
    clear_log();
    busy_len = 1;
    max_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      write_byte(8'h40 + 8'(i));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    wait_drained("t4", 500);
    check("t4_max_count_le2", 32'(max_cnt <= 2), 32'd1);
    check("t4_pulses", 32'(pulses), 32'd40);
    for (int i = 0; i < 40; i++)
      if (i < got.size()) check($sformatf("t4_byte%0d", i), 32'(got[i]), 32'h40 + 32'(i));
    busy_len = 10;

    // 5: simultaneous events at full
    clear_log();
    tx_auto   = 1'b0;
    tx_manual = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i));
    check("t5_full", 32'(full), 32'd1);
    wr_en     = 1'b1;
    wr_data   = 8'hEE;
    tx_manual = 1'b1;
    tick();
    wr_en     = 1'b0;
    tx_manual = 1'b0;
    check("t5_tx_en",    32'(tx_en),    32'd1);
    check("t5_tx_data",  32'(tx_data),  32'h80);
    check("t5_count15",  32'(count),    32'd15);
    check("t5_overflow", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t5_clr_alone_a", 32'(overflow), 32'd0);
    write_byte(8'h90);
    check("t5_refull", 32'(count), 32'd16);
    wr_en        = 1'b1;
    wr_data      = 8'hEF;
    clr_overflow = 1'b1;
    tick();
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    check("t5_set_wins",      32'(overflow), 32'd1);
    check("t5_count_dropped", 32'(count),    32'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t5_clr_alone_b", 32'(overflow), 32'd0);
    check("t5_pulses", 32'(pulses), 32'd1);

    // 6: reset while waiting for the transmitter with three entries queued
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) write_byte(8'h61 + 8'(i));
    tx_manual = 1'b1;
    tick();
    tx_manual = 1'b0;
    check("t6_launch",  32'(tx_en),   32'd1);
    check("t6_data",    32'(tx_data), 32'h61);
    check("t6_count3",  32'(count),   32'd3);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_tx_en", 32'(tx_en), 32'd0);
    clear_log();
    tx_manual = 1'b1;
    repeat (20) tick();
    check("t6_no_stale_launch", 32'(pulses), 32'd0);
    write_byte(8'h5A);
    tick();
    check("t6_idle_tx_en",   32'(tx_en),   32'd1);
    check("t6_idle_tx_data", 32'(tx_data), 32'h5A);
    tx_manual = 1'b0;
    repeat (3) tick();
    check("t6_pulses", 32'(pulses), 32'd1);

    check("no_double_pulse", 32'(doubles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
